// File: rtl/ps2_kbd_fifo_if.sv
// rtl/ps2_kbd_fifo_if.sv - CPU-side bus of the PS/2 keyboard receiver FIFO
//
// Ports (slave = receiver, master = CPU):
//   rd        pop strobe, one cycle, active high
//   data      FIFO head {ext, brk, code[7:0]}
//   ready     FIFO non-empty
//   level     FIFO occupancy, 0..DEPTH
//   overflow  sticky: a code was dropped on a full FIFO
//   frame_err one-cycle pulse per rejected or abandoned frame
//   err_cnt   saturating count of frame_err pulses
`timescale 1ns/1ps
interface ps2_kbd_fifo_if #(
    parameter int DEPTH = 16
);
    localparam int LW = $clog2(DEPTH) + 1;

    logic          rd;
    logic [9:0]    data;
    logic          ready;
    logic [LW-1:0] level;
    logic          overflow;
    logic          frame_err;
    logic [7:0]    err_cnt;

    modport master (output rd, input data, ready, level, overflow, frame_err, err_cnt);
    modport slave  (input rd, output data, ready, level, overflow, frame_err, err_cnt);
endinterface

// File: rtl/ps2_kbd_fifo.sv
// rtl/ps2_kbd_fifo.sv - PS/2 keyboard receiver with prefix decode and FWFT FIFO
//
// Ports:
//   clk       system clock, rising edge
//   rst       asynchronous active-high reset
//   ps2_clk   raw PS/2 clock pin
//   ps2_data  raw PS/2 data pin
//   bus       CPU-side bus (ps2_kbd_fifo_if.slave): rd, data, ready, level,
//             overflow, frame_err, err_cnt
`timescale 1ns/1ps
module ps2_kbd_fifo #(
    parameter int DEPTH       = 16,
    parameter int FILTER_LEN  = 8,
    parameter int TIMEOUT_CYC = 50000,
    parameter int DECODE      = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          ps2_clk,
    input  logic          ps2_data,
    ps2_kbd_fifo_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam int FW = $clog2(FILTER_LEN + 1);
    localparam int TW = $clog2(TIMEOUT_CYC + 1);

    // input path
    logic          clk_s1_q, clk_s1_d, clk_s2_q, clk_s2_d;
    logic          dat_s1_q, dat_s1_d, dat_s2_q, dat_s2_d;
    logic          filt_clk_q, filt_clk_d;
    logic [FW-1:0] filt_cnt_q, filt_cnt_d;
    logic          strobe;

    // deframer and decoder
    logic [3:0]    bit_cnt_q, bit_cnt_d;
    logic [9:0]    shift_q, shift_d;
    logic [TW-1:0] to_cnt_q, to_cnt_d;
    logic          ext_q, ext_d, brk_q, brk_d;
    logic          byte_vld, frame_bad, timeout;
    logic [7:0]    byte_code;
    logic          push_req;
    logic [9:0]    push_word;

    // error reporting
    logic          frame_err_q, frame_err_d;
    logic [7:0]    err_cnt_q, err_cnt_d;

    // FIFO
    logic [9:0]    mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [LW-1:0] level_q, level_d;
    logic          overflow_q, overflow_d;
    logic          pop, push, drop, full;

    always_comb begin
        clk_s1_d   = ps2_clk;
        clk_s2_d   = clk_s1_q;
        dat_s1_d   = ps2_data;
        dat_s2_d   = dat_s1_q;
        filt_clk_d = filt_clk_q;
        filt_cnt_d = '0;
        strobe     = 1'b0;
        // Any sample equal to the filtered level restarts the run count, so a
        // glitch shorter than FILTER_LEN never moves the filtered clock.
        if (clk_s2_q != filt_clk_q) begin
            if (filt_cnt_q == FW'(FILTER_LEN - 1)) begin
                filt_clk_d = clk_s2_q;
                strobe     = filt_clk_q;
            end else begin
                filt_cnt_d = filt_cnt_q + FW'(1);
            end
        end
    end

    always_comb begin
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        to_cnt_d  = to_cnt_q;
        byte_vld  = 1'b0;
        frame_bad = 1'b0;
        timeout   = 1'b0;
        byte_code = shift_q[8:1];
        if (strobe) begin
            to_cnt_d = '0;
            if (bit_cnt_q == 4'd10) begin
                // The stop bit is the current sample; it is never stored.
                bit_cnt_d = '0;
                if (!shift_q[0] && dat_s2_q && (^shift_q[9:1]))
                    byte_vld = 1'b1;
                else
                    frame_bad = 1'b1;
            end else begin
                shift_d[bit_cnt_q] = dat_s2_q;
                bit_cnt_d          = bit_cnt_q + 4'd1;
            end
        end else if (bit_cnt_q != 4'd0) begin
            if (to_cnt_q == TW'(TIMEOUT_CYC - 1)) begin
                to_cnt_d  = '0;
                bit_cnt_d = '0;
                timeout   = 1'b1;
            end else begin
                to_cnt_d = to_cnt_q + TW'(1);
            end
        end else begin
            to_cnt_d = '0;
        end
    end

    always_comb begin
        ext_d     = ext_q;
        brk_d     = brk_q;
        push_req  = 1'b0;
        push_word = {ext_q, brk_q, byte_code};
        // A timeout keeps the prefixes; only a rejected frame discards them.
        if (frame_bad) begin
            ext_d = 1'b0;
            brk_d = 1'b0;
        end else if (byte_vld) begin
            if (DECODE != 0) begin
                if (byte_code == 8'hE0) begin
                    ext_d = 1'b1;
                end else if (byte_code == 8'hF0) begin
                    brk_d = 1'b1;
                end else begin
                    push_req = 1'b1;
                    ext_d    = 1'b0;
                    brk_d    = 1'b0;
                end
            end else begin
                push_req  = 1'b1;
                push_word = {2'b00, byte_code};
            end
        end
    end

    always_comb begin
        frame_err_d = frame_bad | timeout;
        err_cnt_d   = err_cnt_q;
        if (frame_err_d && (err_cnt_q != 8'hFF))
            err_cnt_d = err_cnt_q + 8'd1;
    end

    always_comb begin
        pop  = bus.rd && (level_q != '0);
        full = (level_q == LW'(DEPTH));
        push = push_req && (!full || pop);
        drop = push_req && full && !pop;

        wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;

        level_d = level_q;
        if (push && !pop)
            level_d = level_q + LW'(1);
        else if (pop && !push)
            level_d = level_q - LW'(1);

        overflow_d = overflow_q;
        if (drop)
            overflow_d = 1'b1;
        else if (pop)
            overflow_d = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            clk_s1_q    <= 1'b1;
            clk_s2_q    <= 1'b1;
            dat_s1_q    <= 1'b1;
            dat_s2_q    <= 1'b1;
            filt_clk_q  <= 1'b1;
            filt_cnt_q  <= '0;
            bit_cnt_q   <= '0;
            shift_q     <= '0;
            to_cnt_q    <= '0;
            ext_q       <= 1'b0;
            brk_q       <= 1'b0;
            frame_err_q <= 1'b0;
            err_cnt_q   <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            level_q     <= '0;
            overflow_q  <= 1'b0;
        end else begin
            clk_s1_q    <= clk_s1_d;
            clk_s2_q    <= clk_s2_d;
            dat_s1_q    <= dat_s1_d;
            dat_s2_q    <= dat_s2_d;
            filt_clk_q  <= filt_clk_d;
            filt_cnt_q  <= filt_cnt_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            to_cnt_q    <= to_cnt_d;
            ext_q       <= ext_d;
            brk_q       <= brk_d;
            frame_err_q <= frame_err_d;
            err_cnt_q   <= err_cnt_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            level_q     <= level_d;
            overflow_q  <= overflow_d;
        end
    end

    // Storage is deliberately left out of reset; data is ignored while empty.
    always_ff @(posedge clk) begin
        if (push)
            mem_q[wr_ptr_q] <= push_word;
    end

    assign bus.data      = mem_q[rd_ptr_q];
    assign bus.ready     = (level_q != '0);
    assign bus.level     = level_q;
    assign bus.overflow  = overflow_q;
    assign bus.frame_err = frame_err_q;
    assign bus.err_cnt   = err_cnt_q;
endmodule

// File: tb/tb_ps2_kbd_fifo.sv
// tb/tb_ps2_kbd_fifo.sv - directed self-checking bench for ps2_kbd_fifo
`timescale 1ns/1ps
module tb_ps2_kbd_fifo;
    localparam int DEPTH       = 16;
    localparam int FILTER_LEN  = 8;
    localparam int TIMEOUT_CYC = 200;
    localparam int HALF        = 20;

    logic clk      = 1'b0;
    logic rst      = 1'b1;
    logic ps2_clk  = 1'b1;
    logic ps2_data = 1'b1;

    int n_checks    = 0;
    int n_fail      = 0;
    int ferr_cycles = 0;
    int lat         = -1;
    int n0;

    always #5 clk = ~clk;

    ps2_kbd_fifo_if #(.DEPTH(DEPTH)) bus1 ();
    ps2_kbd_fifo_if #(.DEPTH(DEPTH)) bus0 ();

    ps2_kbd_fifo #(.DEPTH(DEPTH), .FILTER_LEN(FILTER_LEN), .TIMEOUT_CYC(TIMEOUT_CYC), .DECODE(1)) dut1 (
        .clk(clk), .rst(rst), .ps2_clk(ps2_clk), .ps2_data(ps2_data), .bus(bus1)
    );
    ps2_kbd_fifo #(.DEPTH(DEPTH), .FILTER_LEN(FILTER_LEN), .TIMEOUT_CYC(TIMEOUT_CYC), .DECODE(0)) dut0 (
        .clk(clk), .rst(rst), .ps2_clk(ps2_clk), .ps2_data(ps2_data), .bus(bus0)
    );

    always @(negedge clk) if (bus1.frame_err === 1'b1) ferr_cycles++;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Device-to-host frame; bit changes while the clock is high.
    task automatic send_frame(input logic [7:0] code, input bit bad_par, input bit bad_stop,
                              input int nbits, input int glitch_bit, input int rd_at);
        logic [10:0] fr;
        logic [4:0]  lvl0;
        fr[0]    = 1'b0;
        fr[8:1]  = code;
        fr[9]    = ~(^code) ^ bad_par;
        fr[10]   = ~bad_stop;
        lvl0     = bus1.level;
        lat      = -1;
        for (int b = 0; b < nbits; b++) begin
            ps2_data = fr[b];
            for (int j = 0; j < HALF; j++) begin
                @(negedge clk);
                ps2_clk = !(b == glitch_bit && j >= 4 && j < 4 + FILTER_LEN - 3);
            end
            ps2_clk = 1'b0;
            for (int j = 1; j <= HALF; j++) begin
                @(negedge clk);
                bus1.rd = (j == rd_at) && (b == 10);
                if (b == 10 && lat < 0 && bus1.level != lvl0) lat = j;
            end
            bus1.rd = 1'b0;
            ps2_clk = 1'b1;
        end
        ps2_data = 1'b1;
        repeat (2 * HALF) @(negedge clk);
    endtask

    task automatic frame(input logic [7:0] code);
        send_frame(code, 1'b0, 1'b0, 11, -1, 0);
    endtask

    task automatic pop1();
        @(negedge clk) bus1.rd = 1'b1;
        @(negedge clk) bus1.rd = 1'b0;
    endtask

    task automatic pop0();
        @(negedge clk) bus0.rd = 1'b1;
        @(negedge clk) bus0.rd = 1'b0;
    endtask

    task automatic drain1();
        for (int i = 0; i < 40; i++) if (bus1.ready) pop1();
    endtask

    task automatic do_reset();
        @(negedge clk) rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        logic [9:0] raw_exp [5];
        raw_exp = '{10'h0E0, 10'h0F0, 10'h075, 10'h0F0, 10'h01C};
        bus1.rd = 1'b0;
        bus0.rd = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_ready", bus1.ready, 0);
        check("rst_level", bus1.level, 0);
        check("rst_overflow", bus1.overflow, 0);
        check("rst_err_cnt", bus1.err_cnt, 0);
        check("rst_frame_err", bus1.frame_err, 0);
        rst = 1'b0;

        // make code and latency
        frame(8'h1C);
        check("make_latency", (lat > 0 && lat <= FILTER_LEN + 4) ? 1 : 0, 1);
        check("make_ready", bus1.ready, 1);
        check("make_data", bus1.data, 10'h01C);
        check("make_level", bus1.level, 1);
        pop1();
        check("make_pop_ready", bus1.ready, 0);
        check("make_pop_level", bus1.level, 0);

        // prefixes, decoded and raw
        do_reset();
        frame(8'hE0); frame(8'hF0); frame(8'h75);
        check("pfx_level", bus1.level, 1);
        check("pfx_data", bus1.data, 10'h375);
        pop1();
        frame(8'hF0); frame(8'h1C);
        check("brk_level", bus1.level, 1);
        check("brk_data", bus1.data, 10'h11C);
        pop1();
        check("raw_level", bus0.level, 5);
        for (int i = 0; i < 5; i++) begin
            check("raw_entry", bus0.data, raw_exp[i]);
            pop0();
        end
        check("raw_empty", bus0.ready, 0);

        // rejected frames
        n0 = ferr_cycles;
        send_frame(8'h1C, 1'b1, 1'b0, 11, -1, 0);
        check("par_level", bus1.level, 0);
        check("par_pulse", ferr_cycles - n0, 1);
        check("par_err_cnt", bus1.err_cnt, 1);
        send_frame(8'h1C, 1'b0, 1'b1, 11, -1, 0);
        check("stop_level", bus1.level, 0);
        check("stop_err_cnt", bus1.err_cnt, 2);
        frame(8'hE0);
        send_frame(8'h55, 1'b1, 1'b0, 11, -1, 0);
        frame(8'h1C);
        check("clr_level", bus1.level, 1);
        check("clr_data", bus1.data, 10'h01C);
        check("clr_err_cnt", bus1.err_cnt, 3);
        drain1();

        // stalled frame
        n0 = ferr_cycles;
        send_frame(8'h2A, 1'b0, 1'b0, 5, -1, 0);
        repeat (TIMEOUT_CYC + 10) @(negedge clk);
        check("to_pulse", ferr_cycles - n0, 1);
        check("to_err_cnt", bus1.err_cnt, 4);
        check("to_level", bus1.level, 0);
        frame(8'h2A);
        check("to_next_level", bus1.level, 1);
        check("to_next_data", bus1.data, 10'h02A);
        drain1();

        // overflow
        for (int i = 0; i < 17; i++) frame(8'h10 + 8'(i));
        check("ovf_level", bus1.level, 16);
        check("ovf_flag", bus1.overflow, 1);
        check("ovf_head", bus1.data, 10'h010);
        pop1();
        check("ovf_pop_flag", bus1.overflow, 0);
        check("ovf_pop_level", bus1.level, 15);
        check("ovf_pop_head", bus1.data, 10'h011);
        frame(8'h30);
        check("refill_level", bus1.level, 16);
        send_frame(8'h31, 1'b0, 1'b0, 11, -1, FILTER_LEN + 1);
        check("pushpop_level", bus1.level, 16);
        check("pushpop_flag", bus1.overflow, 0);
        check("pushpop_head", bus1.data, 10'h012);
        drain1();

        // clock glitches, idle and mid-frame
        @(negedge clk) ps2_clk = 1'b0;
        repeat (FILTER_LEN - 3) @(negedge clk);
        ps2_clk = 1'b1;
        repeat (HALF) @(negedge clk);
        n0 = ferr_cycles;
        send_frame(8'h33, 1'b0, 1'b0, 11, 3, 0);
        check("glitch_level", bus1.level, 1);
        check("glitch_data", bus1.data, 10'h033);
        check("glitch_no_err", ferr_cycles - n0, 0);
        drain1();

        // asynchronous reset mid-frame
        frame(8'h11); frame(8'h12); frame(8'h13);
        check("pre_rst_level", bus1.level, 3);
        send_frame(8'h44, 1'b0, 1'b0, 3, -1, 0);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("arst_ready", bus1.ready, 0);
        check("arst_level", bus1.level, 0);
        check("arst_err_cnt", bus1.err_cnt, 0);
        @(negedge clk) rst = 1'b0;
        frame(8'h4B);
        check("post_rst_level", bus1.level, 1);
        check("post_rst_data", bus1.data, 10'h04B);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1);
    end
endmodule

// File: doc/ps2_kbd_fifo.md
Name: ps2_kbd_fifo

Overview:
Parametrised PS/2 keyboard receiver: the next generation of our keyboard front end. It synchronises and deglitches ps2_clk and ps2_data, deframes 11-bit frames, and resynchronises on stalled frames. Optionally it folds E0/F0 prefixes into tagged scan codes, then buffers them in a configurable first-word-fall-through FIFO. It sits between the PS/2 pins and the CPU I/O bus, with error statistics for software.

Parameters:
DEPTH, 16, FIFO entries; power of 2, minimum 2.
FILTER_LEN, 8, consecutive equal synchronised samples required before the filtered ps2_clk changes level; minimum 1.
TIMEOUT_CYC, 50000, clk cycles without a filtered falling edge mid-frame before the frame is abandoned.
DECODE, 1, 1 = fold E0/F0 prefixes into tags; 0 = raw bytes.

Ports:
clk  in  1  system clock, all logic on its rising edge.
rst  in  1  asynchronous, active-high reset.
ps2_clk  in  1  raw PS/2 clock from the pin.
ps2_data  in  1  raw PS/2 data from the pin.
rd  in  1  single-cycle pop strobe from the CPU, active high.
data  out  10  FIFO head {ext, brk, code[7:0]}; ext and brk are 0 when DECODE=0.
ready  out  1  FIFO non-empty.
level  out  $clog2(DEPTH)+1  current FIFO occupancy, 0..DEPTH.
overflow  out  1  sticky: a frame was dropped because the FIFO was full.
frame_err  out  1  one-cycle pulse on each rejected or abandoned frame.
err_cnt  out  8  saturating count of frame_err pulses.

Behaviour:
- Reset (asynchronous, clears everything): FIFO pointers, level=0, ready=0, overflow=0, frame_err=0, err_cnt=0. Also bit counter, prefix flags, timeout counter, filter counter=0; synchronisers and filtered clock=1 (bus idle). FIFO storage is not cleared, and data is don't-care while ready=0.
- Input path: 2-flop synchroniser on each of ps2_clk and ps2_data. The filtered clock toggles only after FILTER_LEN consecutive synchronised samples differ from its current value. A sample strobe fires for one cycle on each 1->0 transition of the filtered clock.
- Deframer: 4-bit bit counter, 0..10. Each strobe stores the synchronised ps2_data into a shift buffer at index count and increments count.
  - On the strobe where count==10, the frame is validated: start bit=0, stop bit (current sample)=1, and XOR of data[7:0] and parity bit = 1 (odd parity). count returns to 0.
  - A valid frame produces a byte event in the same edge.
  - An invalid frame pulses frame_err in the next cycle and pushes nothing.
- Timeout: the counter runs while count!=0 and restarts on every strobe. When it reaches TIMEOUT_CYC, count resets to 0, prefix flags are kept, and frame_err pulses once. It is idle when count==0.
- Decode (DECODE=1):
  - Byte 0xE0 sets ext; byte 0xF0 sets brk. Neither is pushed.
  - Any other byte pushes {ext, brk, byte} and clears both flags.
  - An invalid frame clears both flags.
  - DECODE=0: every byte is pushed as {2'b00, byte}.
- FIFO:
  - Push accepted when not full, or when full with a simultaneous pop.
  - Push while full with no pop: the byte is dropped and overflow is set.
  - Pop happens on rd when ready. rd while empty is ignored with no pointer change.
  - A pop clears overflow, unless a drop happens in the same cycle, in which case overflow stays 1.
  - Simultaneous push and pop: level is unchanged.
  - Pointers wrap modulo DEPTH.
  - data reflects the head combinationally from registered storage. The next entry appears the cycle after the pop.
- Latency: raw ps2_clk falling edge of the stop bit to ready=1 is FILTER_LEN+4 clk cycles or fewer.
- err_cnt increments on each frame_err pulse and saturates at 255.

Test Plan:
- Make code: DECODE=1, send frame 0x1C with correct parity -> ready=1 within FILTER_LEN+4 cycles, data=0x01C, level=1; rd pulse -> ready=0, level=0.
- Prefixes: send E0, F0, 75 -> exactly one entry, data=0x375. Then send F0, 1C -> data=0x11C. With DECODE=0 the same stimulus -> five raw entries 0x0E0, 0x0F0, 0x075, 0x0F0, 0x01C.
- Errors:
  - Frame 0x1C with wrong parity -> no push, frame_err pulses 1 cycle, err_cnt=1.
  - Stop bit=0 -> err_cnt=2.
  - Then send E0 followed by a bad frame, then 0x1C -> data=0x01C, confirming the flags were cleared.
- Timeout: send 5 bits, then hold the bus idle for TIMEOUT_CYC+10 cycles -> frame_err pulse. The next full valid frame 0x2A is accepted as data=0x02A.
- Overflow:
  - DEPTH=16, send 17 frames -> level=16, overflow=1, head is still the first code.
  - One rd -> overflow=0, level=15.
  - Fill the FIFO to full again, then issue rd in the same cycle as a push -> level stays 16, overflow stays 0.
- Glitch and reset:
  - A ps2_clk low glitch shorter than FILTER_LEN cycles -> no strobe and count unchanged.
  - Asserting rst mid-frame with 3 entries queued -> ready=0, level=0 immediately (asynchronous). The next full frame decodes correctly.
